// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    // Word index from a byte address; bits above idx_w are dropped so addresses alias.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                                input int unsigned idx_w);
        return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port; contents are never reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WORD_W      = 32,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory target: serialises loads/stores through a fixed-latency
// synchronous RAM, stalling the pipeline while an access is in flight.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_rd_en,
    input  logic              req_wr_en,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              stall,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              req_err
);

    localparam int unsigned      CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_is_wr;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_rd_valid;
    logic              r_err;
    logic              r_has_data;

    logic [31:0]       w_word_idx;
    logic [IDX_W-1:0]  w_idx;
    logic              w_unused_idx;
    logic              w_req_ok;
    logic              w_req_bad;
    logic              w_stall;
    logic              w_latch;
    logic              w_commit;
    logic              w_acc_is_wr;
    logic [IDX_W-1:0]  w_acc_idx;
    logic [WORD_W-1:0] w_acc_wdata;
    logic              w_we;
    logic              w_re;
    logic [WORD_W-1:0] w_rdata;

    assign w_word_idx   = addr_to_idx(req_addr, IDX_W);
    assign w_idx        = w_word_idx[IDX_W-1:0];
    assign w_unused_idx = ^w_word_idx[31:IDX_W];

    assign w_req_ok  = (req_rd_en ^ req_wr_en) && (req_addr[1:0] == 2'b00);
    assign w_req_bad = (req_rd_en || req_wr_en) && !w_req_ok;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_req_ok) begin
                    w_stall = 1'b1;
                    w_latch = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_next = StDone;
                        w_commit     = 1'b1;
                    end else begin
                        w_cnt_next   = CNT_INIT;
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                w_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = StDone;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Single-cycle accesses commit straight from the live request; longer ones from the latch.
    assign w_acc_is_wr = (r_state == StIdle) ? req_wr_en : r_is_wr;
    assign w_acc_idx   = (r_state == StIdle) ? w_idx     : r_idx;
    assign w_acc_wdata = (r_state == StIdle) ? req_wdata : r_wdata;
    assign w_we        = w_commit && reset_n && w_acc_is_wr;
    assign w_re        = w_commit && reset_n && !w_acc_is_wr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_is_wr    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_has_data <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_rd_valid <= w_re;
            r_err      <= (r_state == StIdle) && w_req_bad;
            if (w_latch) begin
                r_is_wr <= req_wr_en;
                r_idx   <= w_idx;
                r_wdata <= req_wdata;
            end
            if (w_re) begin
                r_has_data <= 1'b1;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WORD_W      (WORD_W)
    ) u_array (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_rdata)
    );

    // The RAM read register is unreset, so rd_data is masked until the first completed load.
    assign rd_data  = r_has_data ? w_rdata : '0;
    assign stall    = reset_n && w_stall;
    assign rd_valid = r_rd_valid;
    assign req_err  = r_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the MEM-stage load/store interface, which drives read-enable, write-enable, address and store value.
- Replaces the zero-latency combinational data memory with a word-addressed synchronous RAM that has a configurable access latency.
- Drives a stall back to the pipeline while an access is in flight.
- Returns load data with a one-cycle valid pulse.
- Rejects misaligned and conflicting requests.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 2.
- LATENCY, 2, cycles the requester is stalled per accepted access; at least 1.
- IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, do not override.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_rd_en  in  1  load request; held by the requester while stall=1.
- req_wr_en  in  1  store request; held by the requester while stall=1.
- req_addr  in  32  byte address, equal to the ALU result.
- req_wdata  in  32  store value.
- stall  out  1  freeze the pipeline (combinational from state and request).
- rd_data  out  32  load result, registered.
- rd_valid  out  1  one-cycle pulse; rd_data is new this cycle.
- req_err  out  1  one-cycle pulse; request rejected.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0, latched request cleared.
  - rd_data=0, rd_valid=0, req_err=0, stall=0.
  - RAM contents are not cleared.
- Decode:
  - idx = req_addr[IDX_W+1:2].
  - Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
  - A request is valid when exactly one enable is set and req_addr[1:0]==0.
- State IDLE:
  - Valid request: latch rd/wr, idx and wdata; stall=1 this cycle.
    - LATENCY==1: next state DONE.
    - LATENCY>1: counter=LATENCY-2, next state WAIT.
  - Both enables high, or misaligned address with either enable high:
    - Register req_err=1 for the next cycle.
    - Do not accept; stall=0; stay in IDLE.
    - Misaligned write: RAM unchanged.
  - No enable: stall=0, stay in IDLE.
- State WAIT:
  - stall=1.
  - counter!=0: decrement.
  - counter==0: next state DONE.
  - On that same edge:
    - Latched write: RAM[idx] <= wdata.
    - Latched read: rd_data <= RAM[idx] and rd_valid=1 in DONE.
- LATENCY==1: the commit/read happens on the IDLE->DONE edge instead.
- State DONE:
  - stall=0; rd_valid=1 for reads only.
  - The requester still presents the same request this cycle. It is ignored.
  - Next state is always IDLE.
  - Back-to-back accesses therefore cost LATENCY+1 cycles each.
- Stall length: exactly LATENCY consecutive cycles per accepted access, starting in the cycle the request first appears.
- rd_data holds its value until the next completed read; writes never change rd_data.
- Read-after-write to the same idx returns the new data, since accesses are serialised.
- Enables dropping while in WAIT are a requester protocol violation. The latched access still completes.
- Reset in WAIT:
  - Access aborted; a pending write is not committed.
  - All outputs return to reset values immediately.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, DONE} (2-bit);
  - WORD_W=32;
  - function addr_to_idx.
- One sub-module, dmem_array:
  - single-port synchronous RAM, parameters DEPTH_WORDS and WORD_W;
  - we, idx, wdata, registered rdata; no reset on the array.
- dmem_responder holds the FSM, the latency counter, the request latch and error detection.

Test Plan:
- LATENCY=2, store 0xDEADBEEF to 0x10, then load 0x10:
  - each access gives stall=1 for 2 cycles, then a DONE cycle;
  - the load pulses rd_valid once with rd_data=0xDEADBEEF;
  - the store gives no rd_valid.
- Aliasing with DEPTH_WORDS=256: store 0x11111111 to 0x404, load 0x004 -> rd_data=0x11111111.
- Misaligned load to 0x13:
  - stall stays 0; req_err pulses 1 cycle later; rd_valid stays 0.
  - A following valid load of 0x10 still returns 0xDEADBEEF.
- req_rd_en=req_wr_en=1 to 0x20 with wdata 0x5:
  - req_err pulses; no stall.
  - A subsequent load of 0x20 returns the prior contents, not 0x5.
- Reset mid-access:
  - LATENCY=4; store 0xCAFE to 0x30; drop reset_n in the 2nd WAIT cycle.
  - stall, rd_valid and rd_data go to 0 asynchronously.
  - A later load of 0x30 returns the old value.
- LATENCY=1 sweep of 8 back-to-back stores, then loads of the same addresses:
  - each access gives exactly 1 stall cycle plus 1 DONE cycle;
  - all 8 values read back correctly.
